// File: rtl/psum_accum_drain_pkg.sv
// Shared constants, state type and saturating-add helper for the
// partial-sum accumulate/drain path.
package psum_accum_drain_pkg;

    localparam int NUM_PSUM = 36;
    localparam int PSUM_W   = 24;
    localparam int ACC_W    = 32;
    localparam int OUT_W    = 8;
    localparam int LANES    = 4;
    localparam int BEATS    = NUM_PSUM / LANES;
    localparam int BEAT_W   = 4;
    localparam int SHIFT_W  = 5;
    localparam int IDX_W    = 6;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX = 127;
    localparam logic signed [ACC_W-1:0] OUT_MIN = -128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Accumulator plus sign-extended lane, clamped to the accumulator range
    // so a long run of large partial sums pins at the rail instead of wrapping.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0]  a,
        input logic signed [PSUM_W-1:0] b
    );
        logic [ACC_W:0]          s;
        logic signed [ACC_W-1:0] r;
        s = {a[ACC_W-1], a} + {{(ACC_W+1-PSUM_W){b[PSUM_W-1]}}, b};
        if (s[ACC_W] != s[ACC_W-1])
            r = s[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            r = s[ACC_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/psum_accum_drain_quant.sv
// Per-lane quantiser: optional ReLU, round-half-up arithmetic shift and
// saturation of one accumulator value down to an 8-bit activation.
module psum_quant
    import psum_accum_drain_pkg::*;
(
    input  logic signed [ACC_W-1:0]   acc,
    input  logic                      relu_en,
    input  logic        [SHIFT_W-1:0] shift,
    output logic        [OUT_W-1:0]   q
);

    logic signed [ACC_W-1:0] x;
    logic signed [ACC_W-1:0] xr;
    logic signed [ACC_W-1:0] xs;
    logic        [ACC_W:0]   inc;
    logic        [ACC_W:0]   sum;

    // Rounding increment can only push a value upwards, so only positive
    // overflow of the pre-shift add needs clamping.
    always_comb begin
        x   = (relu_en && acc[ACC_W-1]) ? '0 : acc;
        inc = '0;
        sum = '0;
        xr  = x;
        if (shift != '0) begin
            inc = (ACC_W+1)'(1) << (shift - 5'd1);
            sum = {x[ACC_W-1], x} + inc;
            xr  = (!sum[ACC_W] && sum[ACC_W-1]) ? ACC_MAX : sum[ACC_W-1:0];
        end
        xs = xr >>> shift;
        if (xs > OUT_MAX)
            q = 8'h7F;
        else if (xs < OUT_MIN)
            q = 8'h80;
        else
            q = xs[OUT_W-1:0];
    end

endmodule

// File: rtl/psum_accum_drain.sv
// Accumulates Psum words over channel passes, then drains the quantised
// 36 lanes as LANES-wide beats over a valid/ready bus.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no group open; next Psum word loads the accumulators
//   ACCUM | group open; each Psum word is saturating-added
//   DRAIN | beats presented on out_*; incoming Psum words are dropped
module psum_accum_drain
    import psum_accum_drain_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         Psum_valid,
    input  logic [NUM_PSUM*PSUM_W-1:0]   Psum,
    input  logic                         ch_last,
    input  logic                         relu_en,
    input  logic [SHIFT_W-1:0]           shift,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [LANES*OUT_W-1:0]       out_data,
    output logic [BEAT_W-1:0]            out_beat,
    output logic                         done,
    output logic                         busy,
    output logic                         ovf_err
);

    state_t                     state;
    logic signed [ACC_W-1:0]    acc      [NUM_PSUM];
    logic signed [PSUM_W-1:0]   lane_in  [NUM_PSUM];
    logic signed [ACC_W-1:0]    q_in     [LANES];
    logic                       relu_q;
    logic [SHIFT_W-1:0]         shift_q;
    logic [IDX_W-1:0]           base_idx;

    // Split the flat Psum bus into signed lanes.
    always_comb begin
        for (int k = 0; k < NUM_PSUM; k++)
            lane_in[k] = Psum[k*PSUM_W +: PSUM_W];
    end

    // Accumulator array: load on the first pass, saturating add afterwards,
    // untouched while draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PSUM; k++)
                acc[k] <= '0;
        end else if (Psum_valid && state == IDLE) begin
            for (int k = 0; k < NUM_PSUM; k++)
                acc[k] <= {{(ACC_W-PSUM_W){lane_in[k][PSUM_W-1]}}, lane_in[k]};
        end else if (Psum_valid && state == ACCUM) begin
            for (int k = 0; k < NUM_PSUM; k++)
                acc[k] <= sat_add(acc[k], lane_in[k]);
        end
    end

    // Sequencing FSM with registered handshake, beat counter and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_beat  <= '0;
            done      <= 1'b0;
            ovf_err   <= 1'b0;
            relu_q    <= 1'b0;
            shift_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, ACCUM: begin
                    if (Psum_valid) begin
                        if (ch_last) begin
                            state     <= DRAIN;
                            out_valid <= 1'b1;
                            out_beat  <= '0;
                            relu_q    <= relu_en;
                            shift_q   <= shift;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DRAIN: begin
                    if (Psum_valid)
                        ovf_err <= 1'b1;
                    if (out_valid && out_ready) begin
                        if (out_beat == BEAT_W'(BEATS-1)) begin
                            out_valid <= 1'b0;
                            out_beat  <= '0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            out_beat <= out_beat + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Select the accumulator slice for the current beat.
    always_comb begin
        base_idx = IDX_W'(out_beat * LANES);
        for (int j = 0; j < LANES; j++)
            q_in[j] = acc[base_idx + IDX_W'(j)];
    end

    for (genvar j = 0; j < LANES; j++) begin : g_quant
        psum_quant u_quant (
            .acc     (q_in[j]),
            .relu_en (relu_q),
            .shift   (shift_q),
            .q       (out_data[j*OUT_W +: OUT_W])
        );
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_psum_accum_drain.sv
module tb_psum_accum_drain;
    import psum_accum_drain_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       Psum_valid;
    logic [NUM_PSUM*PSUM_W-1:0] Psum;
    logic                       ch_last;
    logic                       relu_en;
    logic [4:0]                 shift;
    logic                       out_ready;
    logic                       out_valid;
    logic [LANES*OUT_W-1:0]     out_data;
    logic [3:0]                 out_beat;
    logic                       done;
    logic                       busy;
    logic                       ovf_err;

    psum_accum_drain dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Psum_valid (Psum_valid),
        .Psum       (Psum),
        .ch_last    (ch_last),
        .relu_en    (relu_en),
        .shift      (shift),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_beat   (out_beat),
        .done       (done),
        .busy       (busy),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    localparam longint AMAX = 64'sd2147483647;
    localparam longint AMIN = -64'sd2147483648;

    int     checks = 0;
    int     errors = 0;
    longint m_acc [NUM_PSUM];
    int     word_l [NUM_PSUM];
    bit     grp_open = 0;
    bit     m_relu = 0;
    int     m_shift = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint clamp_acc(input longint v);
        if (v > AMAX) return AMAX;
        if (v < AMIN) return AMIN;
        return v;
    endfunction

    function automatic int quant_ref(input longint a, input bit r, input int sh);
        longint x;
        longint lo;
        x = (r && a < 0) ? 0 : a;
        if (sh > 0) begin
            x = x + (longint'(1) <<< (sh - 1));
            if (x > AMAX) x = AMAX;
            x = x >>> sh;
        end
        lo = r ? 0 : -128;
        if (x > 127) x = 127;
        if (x < lo)  x = lo;
        return int'(x);
    endfunction

    function automatic logic [LANES*OUT_W-1:0] exp_beat(input int b);
        logic [LANES*OUT_W-1:0] v;
        int q;
        v = '0;
        for (int j = 0; j < LANES; j++) begin
            q = quant_ref(m_acc[b*LANES + j], m_relu, m_shift);
            v[j*OUT_W +: OUT_W] = q[7:0];
        end
        return v;
    endfunction

    task automatic rand_word(input int r);
        for (int k = 0; k < NUM_PSUM; k++)
            word_l[k] = int'($urandom_range(0, 2*r)) - r;
    endtask

    // Present one word for one cycle and update the reference model.
    task automatic send_word(input bit last);
        for (int k = 0; k < NUM_PSUM; k++)
            Psum[k*PSUM_W +: PSUM_W] = word_l[k][PSUM_W-1:0];
        Psum_valid = 1'b1;
        ch_last    = last;
        for (int k = 0; k < NUM_PSUM; k++)
            m_acc[k] = grp_open ? clamp_acc(m_acc[k] + longint'(word_l[k])) : longint'(word_l[k]);
        grp_open = !last;
        if (last) begin
            m_relu  = relu_en;
            m_shift = int'(shift);
        end
        @(negedge clk);
        Psum_valid = 1'b0;
        ch_last    = 1'b0;
    endtask

    // Drain all beats with random backpressure; optionally inject a word mid-drain.
    task automatic drain_check(input string tag, input int pct, input bit pulse);
        int beat = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [LANES*OUT_W-1:0] held;
        held = '0;
        while (beat < BEATS && cyc < 400) begin
            chk({tag, "_valid"}, out_valid, 1);
            chk({tag, "_beat"}, out_beat, beat);
            chk({tag, "_data"}, out_data, exp_beat(beat));
            if (stalled) chk({tag, "_stable"}, out_data, held);
            held = out_data;
            Psum_valid = (pulse && cyc == 2);
            ch_last    = Psum_valid;
            if (Psum_valid)
                for (int k = 0; k < NUM_PSUM; k++) Psum[k*PSUM_W +: PSUM_W] = 24'($urandom);
            out_ready = ($urandom_range(0, 99) < pct);
            stalled = !out_ready;
            @(negedge clk);
            if (out_ready) beat++;
            cyc++;
        end
        Psum_valid = 1'b0;
        ch_last    = 1'b0;
        out_ready  = 1'b0;
        if (beat < BEATS) chk({tag, "_timeout"}, beat, BEATS);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_end_valid"}, out_valid, 0);
        chk({tag, "_end_busy"}, busy, 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    int t3_val  [4] = '{-50, -50, 1000, -1000};
    bit t3_relu [4] = '{1, 0, 0, 0};
    int t3_exp  [4] = '{8'h00, 8'hCE, 8'h7F, 8'h80};

    initial begin
        rst_n = 1'b0; Psum_valid = 1'b0; Psum = '0; ch_last = 1'b0;
        relu_en = 1'b0; shift = 5'd0; out_ready = 1'b0;
        for (int k = 0; k < NUM_PSUM; k++) m_acc[k] = 0;

        // 1: reset values, then a single all-5 word
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_beat", out_beat, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NUM_PSUM; k++) word_l[k] = 5;
        send_word(1);
        chk("t1_first", out_data, 32'h05050505);
        drain_check("t1", 100, 0);

        // 2: three passes with gaps, shift 4
        relu_en = 1'b0; shift = 5'd4;
        rand_word(20000); word_l[0] = 100; send_word(0);
        repeat (2) begin
            chk("t2_hold_busy", busy, 1);
            chk("t2_hold_valid", out_valid, 0);
            @(negedge clk);
        end
        rand_word(20000); word_l[0] = 200; send_word(0);
        rand_word(20000); word_l[0] = 300; send_word(1);
        chk("t2_lane0", out_data[7:0], 38);
        drain_check("t2", 100, 0);

        // 3: ReLU and output saturation on lane 3
        shift = 5'd0;
        for (int i = 0; i < 4; i++) begin
            relu_en = t3_relu[i];
            for (int k = 0; k < NUM_PSUM; k++) word_l[k] = 0;
            word_l[3] = t3_val[i];
            send_word(1);
            chk("t3_lane3", out_data[3*OUT_W +: OUT_W], t3_exp[i]);
            drain_check("t3", 100, 0);
        end

        // 4: random groups with random backpressure
        for (int g = 0; g < 4; g++) begin
            relu_en = 1'($urandom);
            shift   = 5'($urandom_range(0, 31));
            for (int p = 0, n = int'($urandom_range(1, 4)); p < n; p++) begin
                rand_word(8388607);
                send_word(p == n - 1);
            end
            drain_check("t4", 50, 0);
        end

        // 5: input during drain is dropped and flagged; next group loads fresh
        relu_en = 1'b0; shift = 5'd3;
        rand_word(5000); send_word(0);
        rand_word(5000); send_word(1);
        drain_check("t5", 70, 1);
        chk("t5_ovf", ovf_err, 1);
        shift = 5'd0;
        rand_word(100); send_word(1);
        drain_check("t5b", 100, 0);
        chk("t5_ovf_sticky", ovf_err, 1);

        // 6: accumulator saturation, then reset mid-drain
        relu_en = 1'b0; shift = 5'd0;
        for (int p = 0; p < 300; p++) begin
            rand_word(100);
            word_l[0] = 24'h7FFFFF;
            send_word(p == 299);
        end
        chk("t6_sat_lane0", out_data[7:0], 8'h7F);
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            chk("t6_data", out_data, exp_beat(b));
            @(negedge clk);
        end
        chk("t6_beat4", out_beat, 4);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_busy", busy, 0);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_done", done, 0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < NUM_PSUM; k++) m_acc[k] = 0;
        grp_open = 0;
        @(negedge clk);
        chk("t6_post_data", out_data, 0);
        chk("t6_post_ovf", ovf_err, 0);
        chk("t6_post_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
